// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl -- sequential shift-and-add unsigned multiplier with a
// three-state control FSM (IDLE -> RUN -> DONE).
//
// One multiply takes N RUN cycles. The result is held in DONE until the
// consumer acknowledges it. Abort cancels RUN or DONE and clears the result.
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous active-low reset
//   start     in   1      begin a multiply (accepted only in IDLE)
//   q_in      in   N      multiplier operand
//   m_in      in   N      multiplicand operand
//   done_ack  in   1      consumer acknowledge of a completed result
//   abort     in   1      cancel the current operation
//   ready     out  1      state is IDLE
//   busy      out  1      state is RUN
//   done      out  1      state is DONE
//   prod      out  2N     result register
//   step_cnt  out  clog2(N)+1  RUN steps completed in the current operation
module mul_seq_ctrl #(
   parameter int N = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [N-1:0]         q_in,
   input  logic [N-1:0]         m_in,
   input  logic                 done_ack,
   input  logic                 abort,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [2*N-1:0]       prod,
   output logic [$clog2(N):0]   step_cnt
);

   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [2*N-1:0]   p_r;
   logic [N-1:0]     m_r;
   logic [N:0]       sum_s;
   logic [2*N-1:0]   p_nxt_s;
   logic             last_step_s;
   logic             accept_s;

   // Start is honoured only from IDLE and only when abort is low.
   assign accept_s    = (state_r == IDLE) && start && !abort;
   // The step being performed now is the Nth one.
   assign last_step_s = (step_cnt == CW'(N - 1));

   // One shift-and-add step: add M into the upper half when the LSB is set,
   // keep the carry as the new MSB, and shift the lower half right.
   always_comb begin
      sum_s   = {1'b0, p_r[2*N-1:N]} + (p_r[0] ? {1'b0, m_r} : {(N+1){1'b0}});
      p_nxt_s = {sum_s, p_r[N-1:1]};
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; abort has priority over done_ack and start.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt_s = IDLE;
            end else if (last_step_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE: begin
            if (abort || done_ack) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, result write and abort clearing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p_r      <= {(2*N){1'b0}};
         m_r      <= {N{1'b0}};
         prod     <= {(2*N){1'b0}};
         step_cnt <= {CW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  m_r      <= m_in;
                  p_r      <= {{N{1'b0}}, q_in};
                  step_cnt <= {CW{1'b0}};
               end
            end
            RUN: begin
               if (abort) begin
                  p_r      <= {(2*N){1'b0}};
                  m_r      <= {N{1'b0}};
                  prod     <= {(2*N){1'b0}};
                  step_cnt <= {CW{1'b0}};
               end else begin
                  p_r      <= p_nxt_s;
                  step_cnt <= step_cnt + CW'(1);
                  // The result register is written on the same edge that enters DONE.
                  if (last_step_s) begin
                     prod <= p_nxt_s;
                  end
               end
            end
            DONE: begin
               if (abort) begin
                  p_r      <= {(2*N){1'b0}};
                  m_r      <= {N{1'b0}};
                  prod     <= {(2*N){1'b0}};
                  step_cnt <= {CW{1'b0}};
               end
            end
            default: begin
               p_r      <= {(2*N){1'b0}};
               m_r      <= {N{1'b0}};
               prod     <= {(2*N){1'b0}};
               step_cnt <= {CW{1'b0}};
            end
         endcase
      end
   end

   // Status flags decoded straight from the state register.
   assign ready = (state_r == IDLE);
   assign busy  = (state_r == RUN);
   assign done  = (state_r == DONE);

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl (N=8): table-driven vectors plus
// hand-written corner sequences, with a scoreboard queue of expected products.
module tb_mul_seq_ctrl;

   localparam int N = 8;

   logic            clk;
   logic            reset;
   logic            start;
   logic [N-1:0]    q_in;
   logic [N-1:0]    m_in;
   logic            done_ack;
   logic            abort;
   logic            ready;
   logic            busy;
   logic            done;
   logic [2*N-1:0]  prod;
   logic [$clog2(N):0] step_cnt;

   int checks = 0;
   int errors = 0;
   logic [15:0] sb[$];

   typedef struct {
      logic [7:0]  q;
      logic [7:0]  m;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[5];

   mul_seq_ctrl #(.N(N)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .q_in     (q_in),
      .m_in     (m_in),
      .done_ack (done_ack),
      .abort    (abort),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .prod     (prod),
      .step_cnt (step_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One-hot status flags at every falling edge.
   always @(negedge clk) begin
      chk("onehot_flags", {29'd0, ready, busy, done}, (ready + busy + done == 2'd1) ?
          {29'd0, ready, busy, done} : 32'hFFFF_FFFF);
   end

   // Called at a falling edge with the DUT in IDLE; returns at the falling
   // edge where done is first seen (or after a bounded timeout).
   task automatic start_and_wait(input logic [7:0] q, input logic [7:0] m,
                                 input logic [15:0] exp, input bit timing);
      int e;
      int nb;
      logic [15:0] want;
      q_in  = q;
      m_in  = m;
      start = 1'b1;
      sb.push_back(exp);
      e  = 0;
      nb = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         e++;
         if (busy) nb++;
      end while (!done && e < 40);
      want = sb.pop_front();
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done after %0d edges expected done", e);
      end else begin
         chk("prod", {16'd0, prod}, {16'd0, want});
         chk("step_cnt_done", {28'd0, step_cnt}, 32'd8);
         if (timing) begin
            chk("done_edge", e, 32'd9);
            chk("busy_cycles", nb, 32'd8);
         end
      end
   endtask

   task automatic ack();
      done_ack = 1'b1;
      @(negedge clk);
      done_ack = 1'b0;
      chk("ready_after_ack", {31'd0, ready}, 32'd1);
   endtask

   task automatic check_idle_clear(input string name);
      chk({name, "_ready"}, {31'd0, ready}, 32'd1);
      chk({name, "_busy"}, {31'd0, busy}, 32'd0);
      chk({name, "_done"}, {31'd0, done}, 32'd0);
      chk({name, "_prod"}, {16'd0, prod}, 32'd0);
      chk({name, "_step"}, {28'd0, step_cnt}, 32'd0);
   endtask

   initial begin
      logic [7:0]  rq;
      logic [7:0]  rm;
      int          w;

      vecs[0] = '{q: 8'd13,  m: 8'd11,  exp: 16'h008F};
      vecs[1] = '{q: 8'd255, m: 8'd255, exp: 16'hFE01};
      vecs[2] = '{q: 8'd0,   m: 8'd200, exp: 16'h0000};
      vecs[3] = '{q: 8'd1,   m: 8'd255, exp: 16'h00FF};
      vecs[4] = '{q: 8'd255, m: 8'd0,   exp: 16'h0000};

      reset    = 1'b0;
      start    = 1'b0;
      q_in     = 8'd0;
      m_in     = 8'd0;
      done_ack = 1'b0;
      abort    = 1'b0;

      repeat (2) @(negedge clk);
      check_idle_clear("reset");

      // Release reset and start on the very first active edge.
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         start_and_wait(vecs[i].q, vecs[i].m, vecs[i].exp, 1'b1);
         ack();
      end

      // Abort in RUN at step_cnt == 3.
      q_in  = 8'd5;
      m_in  = 8'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (step_cnt != 4'd3 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("abort_in_run", {31'd0, busy}, 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_idle_clear("abort");
      start_and_wait(8'd6, 8'd7, 16'h002A, 1'b1);
      ack();

      // Hold in DONE for 20 cycles; a start pulse there is ignored.
      start_and_wait(8'd200, 8'd3, 16'h0258, 1'b0);
      for (int i = 0; i < 20; i++) begin
         start = (i == 5);
         q_in  = 8'd1;
         m_in  = 8'd1;
         @(negedge clk);
         chk("hold_prod", {16'd0, prod}, 32'h0258);
         chk("hold_done", {31'd0, done}, 32'd1);
         chk("hold_step", {28'd0, step_cnt}, 32'd8);
      end
      start = 1'b0;
      ack();
      chk("after_hold_prod", {16'd0, prod}, 32'h0258);

      // start coincident with done_ack in DONE is not accepted.
      start_and_wait(8'd2, 8'd2, 16'h0004, 1'b0);
      start    = 1'b1;
      done_ack = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      done_ack = 1'b0;
      chk("ack_start_ready", {31'd0, ready}, 32'd1);
      @(negedge clk);
      chk("ack_start_not_busy", {31'd0, busy}, 32'd0);

      // Asynchronous reset mid-RUN, between clock edges.
      q_in  = 8'd9;
      m_in  = 8'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1 check_idle_clear("async_reset");
      @(negedge clk);
      check_idle_clear("reset_held");
      reset = 1'b1;
      start_and_wait(8'd3, 8'd5, 16'h000F, 1'b1);
      ack();

      // Back-to-back random operations.
      for (int i = 0; i < 1000; i++) begin
         rq = 8'($urandom_range(0, 255));
         rm = 8'($urandom_range(0, 255));
         start_and_wait(rq, rm, {8'd0, rq} * {8'd0, rm}, 1'b0);
         ack();
      end

      // abort + done_ack + start together in DONE: abort wins.
      start_and_wait(8'd100, 8'd100, 16'h2710, 1'b0);
      abort    = 1'b1;
      done_ack = 1'b1;
      start    = 1'b1;
      @(negedge clk);
      abort    = 1'b0;
      done_ack = 1'b0;
      start    = 1'b0;
      check_idle_clear("abort_wins");

      chk("sb_empty", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
